fs_accel_ibuf: RTL and testbench

FS_ACCEL_IBUF -- requirements
Module: fs_accel_ibuf

---
 rtl/fs_accel_pkg.sv | 5 +
 rtl/fs_accel_ibuf_mem.sv | 24 ++
 rtl/fs_accel_ibuf.sv | 92 +++++++++
 tb/tb_fs_accel_ibuf.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fs_accel_pkg.sv
// Shared constants for the accelerator front end: datapath width and default buffer depth.
package fs_accel_pkg;
  localparam int ACCEL_DW   = 32;
  localparam int IBUF_DEPTH = 4;
endpackage

// File: rtl/fs_accel_ibuf_mem.sv
// Input-buffer storage: DEPTH x DW register array, synchronous write, asynchronous read.
module fs_accel_ibuf_mem
  import fs_accel_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int AW    = 2,
  parameter int DW    = ACCEL_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  // Entries are deliberately not reset; the top masks the read data when empty.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/fs_accel_ibuf.sv
// First-word-fall-through input buffer feeding the accelerator datapath.
// Optional sticky overflow/underflow flags are built when FS_ACCEL_IBUF_ERR_EN is defined.
module fs_accel_ibuf
  import fs_accel_pkg::*;
#(
  parameter int DEPTH = IBUF_DEPTH,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enb,
  input  logic [ACCEL_DW-1:0] ibuf_di,
  input  logic                ibuf_wr,
  output logic                ibuf_full,
  output logic [ACCEL_DW-1:0] ibuf_do,
  output logic                ibuf_valid,
  input  logic                ibuf_rd,
  input  logic                ibuf_clr,
  output logic [CNT_W-1:0]    ibuf_cnt
`ifdef FS_ACCEL_IBUF_ERR_EN
  ,
  output logic                ibuf_ovf,
  output logic                ibuf_udf
`endif
);
  localparam int PTR_W = CNT_W - 1;

  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    cnt;
  logic [ACCEL_DW-1:0] mem_rdata;
  logic                rd_acc, wr_acc, clr_acc, mem_we;

  // Handshake: ibuf_valid/ibuf_rd form a valid/ready pair -- a pop happens only
  // on an enabled cycle where both are high; ibuf_rd without ibuf_valid is a no-op.
  // On the write side, ibuf_wr is accepted unless full, or when a pop frees a slot.
  assign ibuf_valid = (cnt != '0);
  assign ibuf_full  = (cnt == CNT_W'(DEPTH));
  assign ibuf_cnt   = cnt;

  assign clr_acc = enb & ibuf_clr;
  assign rd_acc  = enb & ibuf_rd & ibuf_valid;
  assign wr_acc  = enb & ibuf_wr & (~ibuf_full | rd_acc);
  assign mem_we  = wr_acc & ~clr_acc;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr_acc) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_acc && !rd_acc)      cnt <= cnt + CNT_W'(1);
      else if (rd_acc && !wr_acc) cnt <= cnt - CNT_W'(1);
    end
  end

  fs_accel_ibuf_mem #(
    .DEPTH (DEPTH),
    .AW    (PTR_W),
    .DW    (ACCEL_DW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_ptr),
    .wdata (ibuf_di),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Storage is unreset, so the head is forced to zero whenever nothing is held.
  assign ibuf_do = ibuf_valid ? mem_rdata : '0;

`ifdef FS_ACCEL_IBUF_ERR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ibuf_ovf <= 1'b0;
      ibuf_udf <= 1'b0;
    end else if (clr_acc) begin
      ibuf_ovf <= 1'b0;
      ibuf_udf <= 1'b0;
    end else begin
      if (enb && ibuf_wr && !wr_acc)     ibuf_ovf <= 1'b1;
      if (enb && ibuf_rd && !ibuf_valid) ibuf_udf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fs_accel_ibuf.sv
// Directed self-checking bench for fs_accel_ibuf (DEPTH=4); flag checks compile in with FS_ACCEL_IBUF_ERR_EN.
module tb_fs_accel_ibuf;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        enb = 1'b1;
  logic [31:0] ibuf_di = '0;
  logic        ibuf_wr = 1'b0;
  logic        ibuf_rd = 1'b0;
  logic        ibuf_clr = 1'b0;
  logic        ibuf_full, ibuf_valid;
  logic [31:0] ibuf_do;
  logic [2:0]  ibuf_cnt;
`ifdef FS_ACCEL_IBUF_ERR_EN
  logic        ibuf_ovf, ibuf_udf;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q[$];

  fs_accel_ibuf dut (
    .clk        (clk),
    .resetn     (resetn),
    .enb        (enb),
    .ibuf_di    (ibuf_di),
    .ibuf_wr    (ibuf_wr),
    .ibuf_full  (ibuf_full),
    .ibuf_do    (ibuf_do),
    .ibuf_valid (ibuf_valid),
    .ibuf_rd    (ibuf_rd),
    .ibuf_clr   (ibuf_clr),
    .ibuf_cnt   (ibuf_cnt)
`ifdef FS_ACCEL_IBUF_ERR_EN
    ,
    .ibuf_ovf   (ibuf_ovf),
    .ibuf_udf   (ibuf_udf)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Driver: inputs applied 1ns after a rising edge, held for one cycle, sampled 1ns after the next edge.
  task automatic drive(input logic en, input logic wr, input logic [31:0] di,
                       input logic rd, input logic clr);
    enb = en; ibuf_wr = wr; ibuf_di = di; ibuf_rd = rd; ibuf_clr = clr;
    @(posedge clk); #1;
    enb = 1'b1; ibuf_wr = 1'b0; ibuf_di = '0; ibuf_rd = 1'b0; ibuf_clr = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] d);
    drive(1'b1, 1'b1, d, 1'b0, 1'b0);
    if (exp_q.size() < 4) exp_q.push_back(d);
  endtask

  task automatic do_pop(input string tag);
    if (exp_q.size() == 0) check({tag, "_q_empty"}, 32'd1, 32'd0);
    else check(tag, ibuf_do, exp_q.pop_front());
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic check_occ(input string tag);
    check({tag, "_cnt"}, 32'(ibuf_cnt), 32'(exp_q.size()));
    check({tag, "_valid"}, 32'(ibuf_valid), 32'(exp_q.size() != 0));
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(ibuf_valid), 32'd0);
    check("rst_full", 32'(ibuf_full), 32'd0);
    check("rst_cnt", 32'(ibuf_cnt), 32'd0);
    check("rst_do", ibuf_do, 32'h0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Fill A0..A3
    for (int i = 0; i < 4; i++) begin
      do_write(32'hA0 + 32'(i));
      check("fill_cnt", 32'(ibuf_cnt), 32'(i + 1));
    end
    check("fill_full", 32'(ibuf_full), 32'd1);
    check("fill_do", ibuf_do, 32'hA0);

    // Write while full is dropped
    do_write(32'hFF);
    check("ovf_cnt", 32'(ibuf_cnt), 32'd4);
    check("ovf_do", ibuf_do, 32'hA0);
`ifdef FS_ACCEL_IBUF_ERR_EN
    check("ovf_flag", 32'(ibuf_ovf), 32'd1);
`endif
    for (int i = 0; i < 4; i++) do_pop("drain_do");
    check("drain_valid", 32'(ibuf_valid), 32'd0);
    check("drain_do0", ibuf_do, 32'h0);
    check("drain_full", 32'(ibuf_full), 32'd0);

    // Simultaneous read/write while full
    for (int i = 0; i < 4; i++) do_write(32'hD0 + 32'(i));
    check("sim_pre_full", 32'(ibuf_full), 32'd1);
    check("sim_head", ibuf_do, 32'hD0);
    drive(1'b1, 1'b1, 32'hB0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    exp_q.push_back(32'hB0);
    check("sim_cnt", 32'(ibuf_cnt), 32'd4);
    check("sim_full", 32'(ibuf_full), 32'd1);
    for (int i = 0; i < 3; i++) do_pop("sim_pop");
    check("sim_b0", ibuf_do, 32'hB0);
    do_pop("sim_last");
    check_occ("sim_end");

    // Read+write while empty: read ignored, word appears next cycle
    drive(1'b1, 1'b1, 32'hC5, 1'b1, 1'b0);
    exp_q.push_back(32'hC5);
    check("emp_valid", 32'(ibuf_valid), 32'd1);
    check("emp_do", ibuf_do, 32'hC5);
    check("emp_cnt", 32'(ibuf_cnt), 32'd1);
`ifdef FS_ACCEL_IBUF_ERR_EN
    check("udf_flag", 32'(ibuf_udf), 32'd1);
`endif
    do_pop("emp_pop");

    // Wrap: occupancy alternates 1,2 across several pointer wraps
    do_write(32'hE0);
    for (int i = 1; i <= 10; i++) begin
      do_write(32'hE0 + 32'(i));
      check("wrap_cnt2", 32'(ibuf_cnt), 32'd2);
      do_pop("wrap_do");
      check("wrap_cnt1", 32'(ibuf_cnt), 32'd1);
    end
    check("wrap_last", ibuf_do, 32'hEA);
    do_pop("wrap_pop");
    check_occ("wrap_end");

    // Clear beats a same-cycle write
    for (int i = 0; i < 3; i++) do_write(32'h30 + 32'(i));
    check("clr_pre_cnt", 32'(ibuf_cnt), 32'd3);
    drive(1'b1, 1'b1, 32'h99, 1'b0, 1'b1);
    exp_q.delete();
    check("clr_cnt", 32'(ibuf_cnt), 32'd0);
    check("clr_valid", 32'(ibuf_valid), 32'd0);
    check("clr_do", ibuf_do, 32'h0);
`ifdef FS_ACCEL_IBUF_ERR_EN
    check("clr_ovf", 32'(ibuf_ovf), 32'd0);
    check("clr_udf", 32'(ibuf_udf), 32'd0);
`endif
    // Write after clear lands at the head
    do_write(32'h11);
    check("post_clr_do", ibuf_do, 32'h11);

    // Disabled: wr, rd and clr pulses change nothing
    drive(1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
    check("enb_cnt", 32'(ibuf_cnt), 32'd1);
    check("enb_do", ibuf_do, 32'h11);
    do_pop("enb_pop");
    check_occ("enb_end");

    // Asynchronous reset between edges mid-burst
    do_write(32'hF0);
    do_write(32'hF1);
    #2;
    resetn = 1'b0;
    #1;
    exp_q.delete();
    check("arst_valid", 32'(ibuf_valid), 32'd0);
    check("arst_cnt", 32'(ibuf_cnt), 32'd0);
    check("arst_full", 32'(ibuf_full), 32'd0);
    check("arst_do", ibuf_do, 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_write(32'h77);
    check("arst_first_do", ibuf_do, 32'h77);
    check("arst_first_cnt", 32'(ibuf_cnt), 32'd1);
    do_pop("arst_pop");
    check_occ("arst_end");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
